instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch controller that sits between the PC register and the instruction decoder. It reads the PC's ROM address and the synchronous instruction ROM's data, and assembles 1- or 2-byte instructions. It presents each instruction to the decoder over a valid/ready handshake and drives the PC register's increment/load controls, including redirects for taken jumps. After reset it also forces the PC (which has no reset of its own) to 8'h00.

## Interface
- `OPERAND_FLAG_BIT`, 7: opcode bit that marks a 2-byte instruction (opcode + operand).
- `COUNT_W`, 16: width of the retired-instruction counter.

- `Clk`  in  1  rising-edge clock; the single clock of this block.
- `Rst`  in  1  reset, synchronous and active-high.
- `ROM_address`  in  8  current PC value from the PC register.
- `rom_data`  in  8  ROM read data; valid one cycle after `ROM_address` is sampled at a clock edge.
- `pc_inc`  out  1  increment request to the PC register.
- `pc_load`  out  1  load request to the PC register (priority over `pc_inc` at the PC).
- `pc_target`  out  8  load value for the PC register.
- `instr_opcode`  out  8  presented opcode.
- `instr_operand`  out  8  presented operand; 8'h00 for 1-byte instructions.
- `instr_pc`  out  8  address of the presented opcode.
- `instr_valid`  out  1  instruction presented.
- `instr_ready`  in  1  decoder accepts the presented instruction.
- `jump_req`  in  1  taken jump, qualified by `instr_valid & instr_ready`.
- `jump_target`  in  8  jump destination.
- `fetch_count`  out  `COUNT_W`  number of instructions accepted since reset.

## Operation
- FSM states: BOOT, ADDR, OP, ADDR2, ARG, OUT.
- `pc_inc`, `pc_load` and `pc_target` are combinational decodes of state plus the inputs. All other outputs are registered.
- BOOT: `pc_load`=1, `pc_target`=8'h00. Next state is ADDR.
- ADDR: no PC control. The ROM samples `ROM_address`. Latch `instr_pc` <= `ROM_address`. Next state is OP.
- OP: latch `instr_opcode` <= `rom_data`, assert `pc_inc`=1.
  - If `rom_data[OPERAND_FLAG_BIT]`=1, next state is ADDR2.
  - Otherwise clear `instr_operand` to 8'h00 and go to OUT.
- ADDR2: no PC control; the ROM samples the incremented PC. Next state is ARG.
- ARG: latch `instr_operand` <= `rom_data`, assert `pc_inc`=1. Next state is OUT.
- OUT: `instr_valid`=1, and the instruction fields are held stable.
  - If `instr_ready`=0, stay in OUT.
  - If `instr_ready`=1 and `jump_req`=0: go to ADDR.
  - If `instr_ready`=1 and `jump_req`=1: assert `pc_load`=1 with `pc_target`=`jump_target` in that same cycle, then go to ADDR.
- `jump_req` outside an OUT-with-ready cycle is ignored.
- `pc_inc` and `pc_load` are never asserted in the same cycle.
- `fetch_count`:
  - Increments by 1 on every `instr_valid & instr_ready` cycle.
  - Wraps modulo 2^`COUNT_W`.
- PC wrap: the PC register wraps 8'hFF -> 8'h00 on its own. A 2-byte instruction whose opcode is at 8'hFF takes its operand from 8'h00. No special handling is required.
- No prefetch: the next opcode fetch begins only after the current instruction is accepted.

## Timing
- Reset (`Rst`=1 at a rising edge):
  - State goes to BOOT.
  - `instr_valid`, `instr_opcode`, `instr_operand` and `instr_pc` all clear to 0.
  - `fetch_count` clears to 0.
  - While in BOOT, `pc_load`=1 and `pc_target`=8'h00, and `pc_inc`=0.
- Reset mid-operation (any state, including OUT with valid high): the instruction is discarded and not counted. The sequence restarts from BOOT, so the PC returns to 8'h00.
- Latency from entering ADDR to `instr_valid` high:
  - 1-byte instruction: 2 cycles.
  - 2-byte instruction: 4 cycles.
- Throughput with `instr_ready` tied high:
  - 1-byte instructions: one instruction per 3 cycles.
  - 2-byte instructions: one instruction per 5 cycles.
- Jump:
  - The PC equals `jump_target` at the edge ending the accept cycle.
  - The next ADDR fetches from `jump_target`.
  - No instruction from the old path is ever presented.
- Backpressure: OUT may hold indefinitely, and the PC does not change while in OUT.

## Test plan
- **Reset/boot.** Assert `Rst` for 2 cycles, then release with the PC at an arbitrary value (8'h5A).
  - One cycle of `pc_load`=1, `pc_target`=00.
  - The first presented instruction has `instr_pc`=00.
  - `fetch_count`=0 until the first accept.
- **Mixed stream.** ROM[00]=12, ROM[01]=85, ROM[02]=3C, ROM[03]=07, `instr_ready`=1. Presented instructions in order:
  - (pc 00, op 12, arg 00).
  - (pc 01, op 85, arg 3C).
  - (pc 03, op 07, arg 00).
  - Valid rises 3 cycles after BOOT for the first instruction, then 5 and 3 cycles apart; `fetch_count`=3.
- **Backpressure.** `instr_ready`=0 for 6 cycles while the instruction at 00 is presented.
  - Fields stay stable, `pc_inc`=0 and `pc_load`=0.
  - The PC holds at 01.
  - On ready, exactly one accept occurs and `fetch_count`=1.
- **Jump.** With the instruction at 01 presented, drive `jump_req`=1, `jump_target`=40 together with ready.
  - `pc_load`=1 in that cycle and the PC becomes 40.
  - The next `instr_pc`=40.
  - `jump_req`=1 while `instr_ready`=0 causes no load.
- **Wrap.** Jump to FF with ROM[FF]=90, ROM[00]=AB.
  - The instruction is presented as (pc FF, op 90, arg AB).
  - The next `instr_pc`=01.
- **Mid-operation reset.** Pulse `Rst` in the ARG state.
  - `instr_valid` stays 0.
  - `fetch_count`=0.
  - The PC is reloaded to 00 and fetching resumes from 00.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetches 1/2-byte instructions from a synchronous ROM and presents them to the decoder, driving PC inc/load.
// Latency: ADDR→valid in 2 cycles (1-byte) or 4 cycles (2-byte); no prefetch.
// Backpressure: OUT holds fields and the PC until instr_ready; a jump reloads the PC on the accept cycle.
module instr_fetch_unit #(
   parameter int OPERAND_FLAG_BIT = 7,
   parameter int COUNT_W          = 16
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [7:0]         ROM_address,
   input  logic [7:0]         rom_data,
   output logic               pc_inc,
   output logic               pc_load,
   output logic [7:0]         pc_target,
   output logic [7:0]         instr_opcode,
   output logic [7:0]         instr_operand,
   output logic [7:0]         instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               jump_req,
   input  logic [7:0]         jump_target,
   output logic [COUNT_W-1:0] fetch_count
);

   typedef enum logic [2:0] {BOOT, ADDR, OP, ADDR2, ARG, OUT} state_t;

   typedef struct packed {
      logic [7:0] pc;
      logic [7:0] opcode;
      logic [7:0] operand;
   } instr_t;

   state_t state, state_nxt;
   instr_t instr_q;

   always_comb begin
      state_nxt = state;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      pc_target = 8'h00;
      case (state)
         BOOT: begin
            pc_load   = 1'b1;
            state_nxt = ADDR;
         end
         ADDR:  state_nxt = OP;
         OP: begin
            pc_inc    = 1'b1;
            state_nxt = rom_data[OPERAND_FLAG_BIT] ? ADDR2 : OUT;
         end
         ADDR2: state_nxt = ARG;
         ARG: begin
            pc_inc    = 1'b1;
            state_nxt = OUT;
         end
         OUT: begin
            // Jump only counts on the accept cycle, so the PC never moves while held.
            if (instr_ready) begin
               state_nxt = ADDR;
               if (jump_req) begin
                  pc_load   = 1'b1;
                  pc_target = jump_target;
               end
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= BOOT;
         instr_q     <= '0;
         instr_valid <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_nxt;
         instr_valid <= (state_nxt == OUT);
         if (instr_valid && instr_ready)
            fetch_count <= fetch_count + COUNT_W'(1);
         case (state)
            ADDR: instr_q.pc <= ROM_address;
            OP: begin
               instr_q.opcode <= rom_data;
               if (!rom_data[OPERAND_FLAG_BIT])
                  instr_q.operand <= 8'h00;
            end
            ARG: instr_q.operand <= rom_data;
            default: ;
         endcase
      end
   end

   assign instr_pc      = instr_q.pc;
   assign instr_opcode  = instr_q.opcode;
   assign instr_operand = instr_q.operand;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: models the PC register and synchronous ROM, checks directed and random streams.
module tb_instr_fetch_unit;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [7:0]  ROM_address;
   logic [7:0]  rom_data = 8'h00;
   logic        pc_inc, pc_load;
   logic [7:0]  pc_target, instr_opcode, instr_operand, instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        jump_req = 1'b0;
   logic [7:0]  jump_target = 8'h00;
   logic [15:0] fetch_count;

   logic [7:0]  rom [256];
   logic [7:0]  pc = 8'h5A;
   logic        pc_force = 1'b1;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   instr_fetch_unit #(.OPERAND_FLAG_BIT(7), .COUNT_W(16)) dut (
      .Clk(Clk), .Rst(Rst), .ROM_address(ROM_address), .rom_data(rom_data),
      .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
      .instr_opcode(instr_opcode), .instr_operand(instr_operand), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .jump_req(jump_req), .jump_target(jump_target), .fetch_count(fetch_count)
   );

   always #5 Clk = ~Clk;

   // PC register (no reset of its own) and synchronous ROM around the DUT
   assign ROM_address = pc;
   always @(posedge Clk) begin
      if (pc_force)     pc <= 8'h5A;
      else if (pc_load) pc <= pc_target;
      else if (pc_inc)  pc <= pc + 8'd1;
      rom_data <= rom[pc];
   end

   typedef struct {
      logic [7:0] pc;
      logic [7:0] op;
      logic [7:0] arg;
      int         gap;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         tick();
         #1;
         n++;
      end while (!instr_valid && n < 20);
      chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
   endtask

   task automatic do_reset();
      pc_force    = 1'b1;
      Rst         = 1'b1;
      instr_ready = 1'b0;
      jump_req    = 1'b0;
      tick();
      tick();
      Rst      = 1'b0;
      pc_force = 1'b0;
      #1;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_count", {16'd0, fetch_count}, 32'd0);
      chk("boot_load", {31'd0, pc_load}, 32'd1);
      chk("boot_target", {24'd0, pc_target}, 32'd0);
      chk("boot_inc", {31'd0, pc_inc}, 32'd0);
   endtask

   initial begin
      vec_t       tbl [3];
      int         n;
      logic [7:0] exp_pc, exp_op, exp_arg;
      int         accepted;

      tbl[0] = '{pc: 8'h00, op: 8'h12, arg: 8'h00, gap: 3};
      tbl[1] = '{pc: 8'h01, op: 8'h85, arg: 8'h3C, gap: 5};
      tbl[2] = '{pc: 8'h03, op: 8'h07, arg: 8'h00, gap: 3};

      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rom[8'h00] = 8'h12; rom[8'h01] = 8'h85; rom[8'h02] = 8'h3C; rom[8'h03] = 8'h07;
      rom[8'h40] = 8'h22; rom[8'hFF] = 8'h90;

      // Reset, boot and mixed 1/2-byte stream with ready high
      do_reset();
      instr_ready = 1'b1;
      tick();
      #1;
      chk("boot_one_cycle", {31'd0, pc_load}, 32'd0);
      chk("boot_pc", {24'd0, pc}, 32'h00);
      for (int i = 0; i < 3; i++) begin
         wait_valid(n);
         if (i == 0) n = n + 1;
         chk("stream_gap", n, tbl[i].gap);
         chk("stream_pc", {24'd0, instr_pc}, {24'd0, tbl[i].pc});
         chk("stream_op", {24'd0, instr_opcode}, {24'd0, tbl[i].op});
         chk("stream_arg", {24'd0, instr_operand}, {24'd0, tbl[i].arg});
         chk("stream_count", {16'd0, fetch_count}, i);
      end
      tick();
      #1;
      chk("stream_final_count", {16'd0, fetch_count}, 32'd3);

      // Backpressure with a jump request that must be ignored
      do_reset();
      wait_valid(n);
      chk("bp_pc", {24'd0, instr_pc}, 32'h00);
      for (int c = 0; c < 6; c++) begin
         jump_req    = 1'b1;
         jump_target = 8'h77;
         tick();
         #1;
         chk("bp_valid", {31'd0, instr_valid}, 32'd1);
         chk("bp_op", {24'd0, instr_opcode}, 32'h12);
         chk("bp_pc_ctrl", {30'd0, pc_inc, pc_load}, 32'd0);
         chk("bp_pc_hold", {24'd0, pc}, 32'h01);
      end
      jump_req    = 1'b0;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      #1;
      chk("bp_accept_valid", {31'd0, instr_valid}, 32'd0);
      chk("bp_accept_count", {16'd0, fetch_count}, 32'd1);

      // Jump taken on accept
      wait_valid(n);
      chk("jmp_src_pc", {24'd0, instr_pc}, 32'h01);
      chk("jmp_src_arg", {24'd0, instr_operand}, 32'h3C);
      instr_ready = 1'b1;
      jump_req    = 1'b1;
      jump_target = 8'h40;
      #1;
      chk("jmp_load", {31'd0, pc_load}, 32'd1);
      chk("jmp_target", {24'd0, pc_target}, 32'h40);
      chk("jmp_no_inc", {31'd0, pc_inc}, 32'd0);
      tick();
      jump_req    = 1'b0;
      instr_ready = 1'b0;
      #1;
      chk("jmp_pc", {24'd0, pc}, 32'h40);
      wait_valid(n);
      chk("jmp_dst_pc", {24'd0, instr_pc}, 32'h40);
      chk("jmp_dst_op", {24'd0, instr_opcode}, 32'h22);

      // 2-byte instruction at FF takes its operand from 00
      rom[8'h00]  = 8'hAB;
      instr_ready = 1'b1;
      jump_req    = 1'b1;
      jump_target = 8'hFF;
      tick();
      jump_req = 1'b0;
      wait_valid(n);
      chk("wrap_pc", {24'd0, instr_pc}, 32'hFF);
      chk("wrap_op", {24'd0, instr_opcode}, 32'h90);
      chk("wrap_arg", {24'd0, instr_operand}, 32'hAB);
      wait_valid(n);
      chk("wrap_next_pc", {24'd0, instr_pc}, 32'h01);

      // Reset while in ARG of the second instruction
      rom[8'h00] = 8'h12;
      do_reset();
      instr_ready = 1'b1;
      wait_valid(n);
      tick();
      #1;
      chk("mid_pre_count", {16'd0, fetch_count}, 32'd1);
      tick();
      tick();
      tick();
      #1;
      chk("mid_arg_inc", {31'd0, pc_inc}, 32'd1);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      #1;
      chk("mid_valid", {31'd0, instr_valid}, 32'd0);
      chk("mid_count", {16'd0, fetch_count}, 32'd0);
      chk("mid_load", {31'd0, pc_load}, 32'd1);
      tick();
      #1;
      chk("mid_pc", {24'd0, pc}, 32'h00);
      wait_valid(n);
      chk("mid_resume_pc", {24'd0, instr_pc}, 32'h00);
      chk("mid_resume_op", {24'd0, instr_opcode}, 32'h12);

      // Random ROM, ready and jumps against an instruction-level model
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      do_reset();
      exp_pc   = 8'h00;
      accepted = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         instr_ready = ($urandom_range(0, 3) != 0);
         jump_req    = ($urandom_range(0, 4) == 0);
         jump_target = 8'($urandom);
         #1;
         if (pc_inc && pc_load) chk("rnd_exclusive", 32'd1, 32'd0);
         if (instr_valid && !instr_ready)
            chk("rnd_hold_ctrl", {30'd0, pc_inc, pc_load}, 32'd0);
         if (instr_valid && instr_ready) begin
            exp_op  = rom[exp_pc];
            exp_arg = exp_op[7] ? rom[8'(exp_pc + 8'd1)] : 8'h00;
            chk("rnd_pc", {24'd0, instr_pc}, {24'd0, exp_pc});
            chk("rnd_op", {24'd0, instr_opcode}, {24'd0, exp_op});
            chk("rnd_arg", {24'd0, instr_operand}, {24'd0, exp_arg});
            chk("rnd_count", {16'd0, fetch_count}, accepted);
            accepted++;
            if (jump_req) exp_pc = jump_target;
            else          exp_pc = exp_pc + (exp_op[7] ? 8'd2 : 8'd1);
         end
      end
      instr_ready = 1'b0;
      tick();
      #1;
      chk("rnd_final_count", {16'd0, fetch_count}, accepted);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
